// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lends one combinational ALU to two requesters,
// holding registered operands on the ALU for ALU_LAT cycles per operation.
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int OPW     = 3,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    output logic             req0_ready,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_data,
    input  logic             rsp0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             req1_ready,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_data,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_c
);

    generate
        if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_latCheck
            $error("alu_arbiter: ALU_LAT must be within 1..15");
        end
    endgenerate

    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state_q;
    logic             owner_q;
    logic             prio_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] opA_q;
    logic [WIDTH-1:0] opB_q;
    logic [OPW-1:0]   opOp_q;
    logic [WIDTH-1:0] res_q;

    logic grant0;
    logic grant1;
    logic inResp;

    // prio names the requester that wins when both are valid.
    assign grant0 = req0_valid & (~req1_valid | ~prio_q);
    assign grant1 = req1_valid & (~req0_valid | prio_q);

    assign req0_ready = rst_n & (state_q == IDLE) & grant0;
    assign req1_ready = rst_n & (state_q == IDLE) & grant1;

    assign inResp     = (state_q == RESP);
    assign rsp0_valid = inResp & ~owner_q;
    assign rsp1_valid = inResp & owner_q;
    assign rsp0_data  = rsp0_valid ? res_q : '0;
    assign rsp1_data  = rsp1_valid ? res_q : '0;

    assign alu_a  = (state_q == EXEC) ? opA_q  : '0;
    assign alu_b  = (state_q == EXEC) ? opB_q  : '0;
    assign alu_op = (state_q == EXEC) ? opOp_q : '0;

    // Reset drops any operation in flight, so no response is ever issued for it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
            opA_q   <= '0;
            opB_q   <= '0;
            opOp_q  <= '0;
            res_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant0) begin
                        opA_q   <= req0_a;
                        opB_q   <= req0_b;
                        opOp_q  <= req0_op;
                        owner_q <= 1'b0;
                        prio_q  <= 1'b1;
                        cnt_q   <= CNT_INIT;
                        state_q <= EXEC;
                    end else if (grant1) begin
                        opA_q   <= req1_a;
                        opB_q   <= req1_b;
                        opOp_q  <= req1_op;
                        owner_q <= 1'b1;
                        prio_q  <= 1'b0;
                        cnt_q   <= CNT_INIT;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q == 4'd0) begin
                        res_q   <= alu_c;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (owner_q ? rsp1_ready : rsp0_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: drivers push hand-computed results, a
// negedge monitor pops and compares whenever a response is consumed.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_data, rsp1_data;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [31:0] alu_a, alu_b, alu_c;
    logic [2:0]  alu_op;

    logic        bReq1Valid = 1'b0;
    logic        bReq1Ready, bReq0Ready, bRsp0Valid, bRsp1Valid;
    logic [31:0] bRsp0Data, bRsp1Data, bAluA, bAluB, bAluC;
    logic [2:0]  bAluOp;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] exp0[$];
    logic [31:0] exp1[$];
    int          grantLog[$];
    logic        prevValid[2];
    logic        prevReady[2];
    logic [31:0] prevData[2];
    int          lastGrant[2];
    int          lastAny = -100;

    assign alu_c  = alu_a ^ alu_b ^ {29'b0, alu_op};
    assign bAluC  = bAluA ^ bAluB ^ {29'b0, bAluOp};

    alu_arbiter #(.WIDTH(32), .OPW(3), .ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .rsp1_ready(rsp1_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c)
    );

    alu_arbiter #(.WIDTH(32), .OPW(3), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(1'b0), .req0_a(32'h0), .req0_b(32'h0), .req0_op(3'h0),
        .req0_ready(bReq0Ready), .rsp0_valid(bRsp0Valid), .rsp0_data(bRsp0Data),
        .rsp0_ready(1'b1),
        .req1_valid(bReq1Valid), .req1_a(32'd5), .req1_b(32'd3), .req1_op(3'd0),
        .req1_ready(bReq1Ready), .rsp1_valid(bRsp1Valid), .rsp1_data(bRsp1Data),
        .rsp1_ready(1'b1),
        .alu_a(bAluA), .alu_b(bAluB), .alu_op(bAluOp), .alu_c(bAluC)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outputsOr();
        return 32'(req0_ready | req1_ready | rsp0_valid | rsp1_valid | (|rsp0_data)
                   | (|rsp1_data) | (|alu_a) | (|alu_b) | (|alu_op));
    endfunction

    // Drives one operation, waits (bounded) for acceptance and pushes the expected result.
    task automatic applyStimulus(input int port, input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op, input logic [31:0] expRes, output int acc);
        if (port == 0) begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end
        acc = -1;
        for (int i = 0; i < 50 && acc < 0; i++) begin
            @(negedge clk);
            #1;
            if ((port == 0) ? req0_ready : req1_ready) begin
                acc = cyc;
                if (port == 0) exp0.push_back(expRes);
                else exp1.push_back(expRes);
            end
        end
        if (acc < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL acceptTimeout port%0d: got no ready, expected ready within 50 cycles", port);
        end
        @(posedge clk);
        #2;
        if (port == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    task automatic monitorPort(input int p, input logic v, input logic r, input logic [31:0] d);
        logic [31:0] e;
        if (!v) checkOutput($sformatf("rsp%0dDataIdle", p), d, 32'h0);
        if (v && !prevValid[p]) checkOutput($sformatf("rsp%0dLatency", p), 32'(cyc - lastGrant[p]), 32'd2);
        if (v && prevValid[p] && !prevReady[p]) checkOutput($sformatf("rsp%0dStable", p), d, prevData[p]);
        if (v) checkOutput("noAcceptInResp", 32'(req0_ready | req1_ready), 32'h0);
        if (v && r) begin
            if ((p == 0 && exp0.size() == 0) || (p == 1 && exp1.size() == 0)) begin
                checks++;
                errors++;
                $display("[TB] FAIL rsp%0dUnexpected: got response 0x%08h, expected none", p, d);
            end else begin
                e = (p == 0) ? exp0.pop_front() : exp1.pop_front();
                checkOutput($sformatf("rsp%0dData", p), d, e);
            end
        end
        prevValid[p] = v;
        prevReady[p] = r;
        prevData[p]  = d;
    endtask

    // Monitor: samples on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp0.delete();
            exp1.delete();
            prevValid = '{1'b0, 1'b0};
            prevReady = '{1'b0, 1'b0};
            lastGrant = '{-100, -100};
            lastAny   = -100;
        end else begin
            if (req0_ready && req1_ready) checkOutput("oneHotReady", 32'h3, 32'h1);
            if (req0_ready || req1_ready) begin
                if (cyc - lastAny < 3) checkOutput("grantGap", 32'(cyc - lastAny), 32'd3);
                lastAny = cyc;
                lastGrant[req1_ready ? 1 : 0] = cyc;
                grantLog.push_back(req1_ready ? 1 : 0);
            end
            monitorPort(0, rsp0_valid, rsp0_ready, rsp0_data);
            monitorPort(1, rsp1_valid, rsp1_ready, rsp1_data);
        end
    end

    task automatic pulseReset();
        rst_n = 1'b0;
        #1;
        checkOutput("asyncResetOutputs", outputsOr(), 32'h0);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int acc;
        int relCyc;
        int c;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("idleOutputs", outputsOr(), 32'h0);
        end

        @(posedge clk);
        #2;
        applyStimulus(0, 32'hffff_fffe, 32'h0000_0002, 3'b100, 32'hffff_fff8, acc);
        @(negedge clk);
        checkOutput("req0ReadyOneCycle", 32'(req0_ready), 32'h0);
        repeat (3) @(posedge clk);
        #2;

        applyStimulus(1, 32'h0000_00ff, 32'h0000_000f, 3'd2, 32'h0000_00f2, acc);
        repeat (3) @(posedge clk);
        #2;

        grantLog.delete();
        fork
            begin
                int a0;
                applyStimulus(0, 32'h1234_5678, 32'h0f0f_0f0f, 3'd1, 32'h1d3b_5976, a0);
                applyStimulus(0, 32'h0000_0000, 32'h0000_0000, 3'd0, 32'h0000_0000, a0);
            end
            begin
                int a1;
                applyStimulus(1, 32'haaaa_aaaa, 32'h5555_5555, 3'd7, 32'hffff_fff8, a1);
                applyStimulus(1, 32'h8000_0000, 32'h0000_0001, 3'd3, 32'h8000_0002, a1);
            end
        join
        checkOutput("contentionCount", 32'(grantLog.size()), 32'd4);
        if (grantLog.size() == 4)
            checkOutput("grantOrder", {grantLog[0][7:0], grantLog[1][7:0], grantLog[2][7:0],
                                       grantLog[3][7:0]}, 32'h0001_0001);
        repeat (4) @(posedge clk);
        #2;

        rsp1_ready = 1'b0;
        applyStimulus(1, 32'hdead_beef, 32'h0000_ffff, 3'd5, 32'hdead_4115, acc);
        relCyc = -1;
        fork
            applyStimulus(0, 32'h0000_0001, 32'h0000_0001, 3'd6, 32'h0000_0006, acc);
            begin
                c = 0;
                while (!rsp1_valid && c < 20) begin
                    @(negedge clk);
                    c++;
                end
                checkOutput("rsp1Pending", 32'(rsp1_valid), 32'h1);
                repeat (5) @(negedge clk);
                @(posedge clk);
                #2;
                rsp1_ready = 1'b1;
                relCyc = cyc;
            end
        join
        checkOutput("acceptAfterRelease", 32'(acc - relCyc), 32'd1);
        repeat (4) @(posedge clk);
        #2;

        applyStimulus(0, 32'h0000_0003, 32'h0000_0004, 3'd0, 32'h0000_0007, acc);
        pulseReset();
        repeat (4) @(posedge clk);
        #2;
        grantLog.delete();
        fork
            applyStimulus(0, 32'h0000_000a, 32'h0000_0014, 3'd0, 32'h0000_001e, acc);
            begin
                int a1;
                applyStimulus(1, 32'h0000_ff00, 32'h0000_00ff, 3'd1, 32'h0000_fffe, a1);
            end
        join
        checkOutput("prioAfterExecReset", 32'(grantLog.size() > 0 ? grantLog[0] : 9), 32'h0);
        repeat (4) @(posedge clk);
        #2;

        rsp0_ready = 1'b0;
        applyStimulus(0, 32'h0000_0007, 32'h0000_0007, 3'd2, 32'h0000_0002, acc);
        c = 0;
        while (!rsp0_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        checkOutput("rsp0HeldInResp", 32'(rsp0_valid), 32'h1);
        @(posedge clk);
        #2;
        pulseReset();
        rsp0_ready = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        grantLog.delete();
        fork
            applyStimulus(0, 32'h0000_0064, 32'h0000_0001, 3'd0, 32'h0000_0065, acc);
            begin
                int a1;
                applyStimulus(1, 32'h0000_0003, 32'h0000_0003, 3'd4, 32'h0000_0004, a1);
            end
        join
        checkOutput("prioAfterRespReset", 32'(grantLog.size() > 0 ? grantLog[0] : 9), 32'h0);
        repeat (5) @(posedge clk);
        #2;
        checkOutput("exp0Drained", 32'(exp0.size()), 32'h0);
        checkOutput("exp1Drained", 32'(exp1.size()), 32'h0);

        bReq1Valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 20 && acc < 0; i++) begin
            @(negedge clk);
            if (bReq1Ready) acc = cyc;
        end
        checkOutput("lat3Accept", 32'(acc >= 0), 32'h1);
        @(posedge clk);
        #2;
        bReq1Valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("lat3AluA", bAluA, 32'd5);
            checkOutput("lat3AluB", bAluB, 32'd3);
            checkOutput("lat3AluOp", 32'(bAluOp), 32'd0);
            checkOutput("lat3NoRspYet", 32'(bRsp1Valid), 32'h0);
        end
        @(negedge clk);
        checkOutput("lat3RspValid", 32'(bRsp1Valid), 32'h1);
        checkOutput("lat3RspData", bRsp1Data, 32'h0000_0006);
        checkOutput("lat3AluReleased", bAluA, 32'h0);
        checkOutput("lat3Rsp0Quiet", 32'(bRsp0Valid | bReq0Ready) | bRsp0Data, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
